i2c_reg_seq_cfg: RTL and testbench

I2C_REG_SEQ_CFG -- requirements
Module: i2c_reg_seq_cfg

---
 rtl/i2c_reg_seq_cfg.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_reg_seq_cfg.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_seq_cfg.sv
// Power-up sequencer: pulses the chip reset, waits for start-up, then replays
// a register table over I2C with optional write-verify retries and delays.
module i2c_reg_seq_cfg #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int REG_NUM   = 64,
  parameter int RST_CYC   = 1000,
  parameter int START_CYC = 5000,
  parameter int MAX_RETRY = 3,
  localparam int IDX_W =
    (REG_NUM > 1) ? $clog2(REG_NUM) : 1,
  localparam int ENT_W = 2 + ADDR_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     restart,
  output logic [IDX_W-1:0]         tbl_idx,
  input  logic [ENT_W-1:0]         tbl_entry,
  output logic                     i2c_exec,
  output logic [ADDR_W+DATA_W-1:0] i2c_data,
  output logic                     i2c_rh_wl,
  input  logic                     i2c_done,
  input  logic [DATA_W-1:0]        i2c_data_r,
  output logic                     rstn_out,
  output logic                     busy,
  output logic                     init_done,
  output logic                     cfg_err,
  output logic [IDX_W-1:0]         err_idx
);

  localparam int DLY_MAX = ((1 << DATA_W) - 1) * 64;
  localparam int C1 =
    (RST_CYC > START_CYC) ? RST_CYC : START_CYC;
  localparam int C2 = (C1 > DLY_MAX) ? C1 : DLY_MAX;
  localparam int CNT_W = $clog2(C2 + 1);
  localparam int RTY_W =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    CHIP_RST,
    PWR_WAIT,
    FETCH,
    ISSUE_WR,
    WAIT_WR,
    ISSUE_RD,
    WAIT_RD,
    DLY,
    NEXT,
    DONE,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_WRV = 2'b01,
    OP_DLY = 2'b10,
    OP_END = 2'b11
  } op_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [RTY_W-1:0]           retry_q, retry_d;
  op_e                        op_q, op_d;
  logic [DATA_W-1:0]          dly_q, dly_d;
  logic [ADDR_W+DATA_W-1:0]   data_q, data_d;
  logic                       rh_wl_q, rh_wl_d;
  logic                       rstn_q, rstn_d;
  logic [IDX_W-1:0]           err_idx_q, err_idx_d;

  op_e                        ent_op;
  logic [ADDR_W-1:0]          ent_addr;
  logic [DATA_W-1:0]          ent_data;
  logic [DATA_W+5:0]          dly_cyc;
  logic [CNT_W-1:0]           dly_last;

  assign ent_op   = op_e'(tbl_entry[ENT_W-1 -: 2]);
  assign ent_addr = tbl_entry[DATA_W +: ADDR_W];
  assign ent_data = tbl_entry[DATA_W-1:0];

  // A zero delay still spends one cycle in DLY.
  assign dly_cyc  = {dly_q, 6'd0};
  assign dly_last = (dly_q == '0) ? '0 :
                    CNT_W'(dly_cyc - 1'b1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    op_d      = op_q;
    dly_d     = dly_q;
    data_d    = data_q;
    rh_wl_d   = rh_wl_q;
    rstn_d    = rstn_q;
    err_idx_d = err_idx_q;

    unique case (state_q)
      CHIP_RST: begin
        rstn_d = 1'b0;
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          cnt_d   = '0;
          rstn_d  = 1'b1;
          state_d = PWR_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PWR_WAIT: begin
        if (cnt_q == CNT_W'(START_CYC - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FETCH: begin
        // First cycle lets the table output settle.
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          cnt_d = '0;
          op_d  = ent_op;
          unique case (ent_op)
            OP_WR, OP_WRV: begin
              data_d  = {ent_addr, ent_data};
              rh_wl_d = 1'b0;
              state_d = ISSUE_WR;
            end
            OP_DLY: begin
              dly_d   = ent_data;
              state_d = DLY;
            end
            OP_END: state_d = DONE;
          endcase
        end
      end
      ISSUE_WR: state_d = WAIT_WR;
      WAIT_WR: begin
        if (i2c_done) begin
          if (op_q == OP_WRV) begin
            rh_wl_d = 1'b1;
            state_d = ISSUE_RD;
          end else begin
            state_d = NEXT;
          end
        end
      end
      ISSUE_RD: state_d = WAIT_RD;
      WAIT_RD: begin
        if (i2c_done) begin
          if (i2c_data_r == data_q[DATA_W-1:0]) begin
            state_d = NEXT;
          end else if (retry_q == RTY_W'(MAX_RETRY)) begin
            err_idx_d = idx_q;
            state_d   = ERR;
          end else begin
            retry_d = retry_q + 1'b1;
            rh_wl_d = 1'b0;
            state_d = ISSUE_WR;
          end
        end
      end
      DLY: begin
        if (cnt_q == dly_last) begin
          cnt_d   = '0;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NEXT: begin
        retry_d = '0;
        if (idx_q == IDX_W'(REG_NUM - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE, ERR: state_d = state_q;
      default:   state_d = CHIP_RST;
    endcase

    if (restart) begin
      state_d   = CHIP_RST;
      cnt_d     = '0;
      idx_d     = '0;
      retry_d   = '0;
      err_idx_d = '0;
      rstn_d    = 1'b0;
      rh_wl_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CHIP_RST;
      cnt_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      op_q      <= OP_WR;
      dly_q     <= '0;
      data_q    <= '0;
      rh_wl_q   <= 1'b0;
      rstn_q    <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      op_q      <= op_d;
      dly_q     <= dly_d;
      data_q    <= data_d;
      rh_wl_q   <= rh_wl_d;
      rstn_q    <= rstn_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign tbl_idx   = idx_q;
  assign i2c_exec  = (state_q == ISSUE_WR) ||
                     (state_q == ISSUE_RD);
  assign i2c_data  = data_q;
  assign i2c_rh_wl = rh_wl_q;
  assign rstn_out  = rstn_q;
  assign busy      = (state_q != DONE) &&
                     (state_q != ERR);
  assign init_done = (state_q == DONE);
  assign cfg_err   = (state_q == ERR);
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_i2c_reg_seq_cfg.sv
// Directed bench for i2c_reg_seq_cfg: table ROM model plus an I2C
// responder that answers every exec 20 cycles later.
module tb_i2c_reg_seq_cfg;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int RN   = 8;
  localparam int IW   = 3;
  localparam int EW   = 2 + AW + DW;
  localparam int RESP = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          restart = 1'b0;
  logic [IW-1:0] tbl_idx;
  logic [EW-1:0] tbl_entry;
  logic          i2c_exec;
  logic [AW+DW-1:0] i2c_data;
  logic          i2c_rh_wl;
  logic          i2c_done;
  logic [DW-1:0] i2c_data_r;
  logic          rstn_out, busy, init_done, cfg_err;
  logic [IW-1:0] err_idx;

  logic [EW-1:0] rom [RN];
  logic          resp_done = 1'b0;
  logic          spur_done = 1'b0;
  logic [DW-1:0] rd_val = '0;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            overlap = 0;
  int            unstable = 0;
  int            ex_cyc[$];
  logic [AW-1:0] ex_addr[$];
  logic          ex_rw[$];

  i2c_reg_seq_cfg #(
    .ADDR_W(AW), .DATA_W(DW), .REG_NUM(RN),
    .RST_CYC(1000), .START_CYC(5000), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .i2c_exec(i2c_exec), .i2c_data(i2c_data),
    .i2c_rh_wl(i2c_rh_wl), .i2c_done(i2c_done),
    .i2c_data_r(i2c_data_r), .rstn_out(rstn_out),
    .busy(busy), .init_done(init_done),
    .cfg_err(cfg_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tbl_entry <= rom[tbl_idx];
  assign i2c_done = resp_done | spur_done;

  function automatic logic [EW-1:0] ent(
    input logic [1:0] op, input logic [AW-1:0] a,
    input logic [DW-1:0] d);
    return {op, a, d};
  endfunction

  initial begin : responder
    logic [AW+DW-1:0] held;
    i2c_data_r = '0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (i2c_exec === 1'b1) begin
        ex_cyc.push_back(cyc);
        ex_addr.push_back(i2c_data[DW +: AW]);
        ex_rw.push_back(i2c_rh_wl);
        held = i2c_data;
        for (int k = 0; k < RESP; k++) begin
          @(negedge clk);
          if (i2c_exec === 1'b1) overlap++;
          if (i2c_data !== held) unstable++;
        end
        i2c_data_r = i2c_rh_wl ? rd_val : '0;
        resp_done = 1'b1;
      end
    end
  end

  task automatic clear_log();
    ex_cyc.delete();
    ex_addr.delete();
    ex_rw.delete();
    overlap = 0;
    unstable = 0;
  endtask

  task automatic start_run();
    clear_log();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_exec(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (i2c_exec === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_writes();
    for (int i = 0; i < RN; i++)
      rom[i] = ent(2'b11, '0, '0);
    for (int i = 0; i < 3; i++)
      rom[i] = ent(2'b00, AW'(16'h0100 + i), DW'(8'h10 + i));
  endtask

  task automatic test_reset();
    load_writes();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rstn_out, i2c_exec, i2c_rh_wl, busy, init_done, cfg_err}
        !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000100",
        {rstn_out, i2c_exec, i2c_rh_wl, busy, init_done, cfg_err});
    end
    n_tests++;
    if ({i2c_data, tbl_idx, err_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got data=%h idx=%0d err=%0d expected 0",
        i2c_data, tbl_idx, err_idx);
    end
  endtask

  task automatic test_powerup();
    int n = 0;
    int m = 0;
    clear_log();
    rst_n = 1'b1;
    while (rstn_out !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n != 1000) begin
      n_fail++;
      $display("FAIL chip_rst_len: got %0d expected 1000", n);
    end
    while (i2c_exec !== 1'b1 && m < 6000) begin
      @(negedge clk);
      m++;
    end
    n_tests++;
    if (m != 5002) begin
      n_fail++;
      $display("FAIL start_len: got %0d expected 5002", m);
    end
    n_tests++;
    if ({tbl_idx, i2c_rh_wl} !== {3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_exec: got idx=%0d rw=%b expected idx=0 rw=0",
        tbl_idx, i2c_rh_wl);
    end
  endtask

  task automatic test_write_seq();
    bit ok;
    wait_idle(ok);
    n_tests++;
    if (!ok || ex_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL wr_count: got ok=%0d n=%0d expected 3",
        ok, ex_cyc.size());
    end
    n_tests++;
    if (ex_cyc[1] - ex_cyc[0] != 24 || ex_cyc[2] - ex_cyc[1] != 24) begin
      n_fail++;
      $display("FAIL wr_gap: got %0d,%0d expected 24,24",
        ex_cyc[1] - ex_cyc[0], ex_cyc[2] - ex_cyc[1]);
    end
    n_tests++;
    if ({init_done, busy, cfg_err, tbl_idx} !== {3'b100, 3'd3}) begin
      n_fail++;
      $display("FAIL wr_end: got done=%b busy=%b err=%b idx=%0d expected 1 0 0 3",
        init_done, busy, cfg_err, tbl_idx);
    end
    n_tests++;
    if (overlap != 0 || unstable != 0) begin
      n_fail++;
      $display("FAIL wr_bus: got overlap=%0d unstable=%0d expected 0 0",
        overlap, unstable);
    end
  endtask

  task automatic test_verify_ok();
    bit ok;
    rom[0] = ent(2'b01, 16'h0531, 8'h84);
    rom[1] = ent(2'b11, '0, '0);
    rd_val = 8'h84;
    start_run();
    wait_idle(ok);
    n_tests++;
    if (!ok || ex_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL wv_count: got ok=%0d n=%0d expected 2",
        ok, ex_cyc.size());
    end
    n_tests++;
    if ({ex_rw[0], ex_rw[1], ex_addr[1]} !== {2'b01, 16'h0531}) begin
      n_fail++;
      $display("FAIL wv_read: got rw=%b%b addr=%h expected 01 0531",
        ex_rw[0], ex_rw[1], ex_addr[1]);
    end
    n_tests++;
    if (ex_cyc[1] - ex_cyc[0] != 21) begin
      n_fail++;
      $display("FAIL wv_gap: got %0d expected 21",
        ex_cyc[1] - ex_cyc[0]);
    end
    n_tests++;
    if ({init_done, cfg_err, tbl_idx} !== {2'b10, 3'd1}) begin
      n_fail++;
      $display("FAIL wv_end: got done=%b err=%b idx=%0d expected 1 0 1",
        init_done, cfg_err, tbl_idx);
    end
  endtask

  task automatic test_verify_fail();
    bit ok;
    int rd = 0;
    rom[0] = ent(2'b00, 16'h0010, 8'h11);
    rom[1] = ent(2'b01, 16'h0020, 8'h55);
    rom[2] = ent(2'b11, '0, '0);
    rd_val = 8'h00;
    start_run();
    wait_idle(ok);
    foreach (ex_rw[i]) if (ex_rw[i]) rd++;
    n_tests++;
    if (!ok || ex_cyc.size() != 9 || rd != 4) begin
      n_fail++;
      $display("FAIL retry_count: got ok=%0d n=%0d reads=%0d expected 9 4",
        ok, ex_cyc.size(), rd);
    end
    n_tests++;
    if ({cfg_err, init_done, busy, err_idx} !== {3'b100, 3'd1}) begin
      n_fail++;
      $display("FAIL retry_err: got err=%b done=%b busy=%b idx=%0d expected 1 0 0 1",
        cfg_err, init_done, busy, err_idx);
    end
  endtask

  task automatic test_delay();
    bit ok;
    rom[0] = ent(2'b00, 16'h0200, 8'hA0);
    rom[1] = ent(2'b10, '0, 8'h02);
    rom[2] = ent(2'b00, 16'h0201, 8'hA1);
    rom[3] = ent(2'b10, '0, 8'h00);
    rom[4] = ent(2'b00, 16'h0202, 8'hA2);
    rom[5] = ent(2'b11, '0, '0);
    start_run();
    wait_exec(ok);
    repeat (RESP + 24) @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    wait_idle(ok);
    n_tests++;
    if (!ok || ex_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL dly_count: got ok=%0d n=%0d expected 3",
        ok, ex_cyc.size());
    end
    n_tests++;
    if (ex_cyc[1] - ex_cyc[0] != 155) begin
      n_fail++;
      $display("FAIL dly_128: got %0d expected 155",
        ex_cyc[1] - ex_cyc[0]);
    end
    n_tests++;
    if (ex_cyc[2] - ex_cyc[1] != 28) begin
      n_fail++;
      $display("FAIL dly_zero: got %0d expected 28",
        ex_cyc[2] - ex_cyc[1]);
    end
    n_tests++;
    if ({init_done, tbl_idx} !== {1'b1, 3'd5}) begin
      n_fail++;
      $display("FAIL dly_end: got done=%b idx=%0d expected 1 5",
        init_done, tbl_idx);
    end
  endtask

  task automatic test_restart();
    bit ok;
    load_writes();
    clear_log();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_tests++;
    if ({rstn_out, cfg_err, busy, err_idx} !== {3'b001, 3'd0}) begin
      n_fail++;
      $display("FAIL rs_from_err: got rstn=%b err=%b busy=%b idx=%0d expected 0 0 1 0",
        rstn_out, cfg_err, busy, err_idx);
    end
    wait_exec(ok);
    repeat (5) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_tests++;
    if ({ok, rstn_out, busy, tbl_idx} !== {3'b101, 3'd0}) begin
      n_fail++;
      $display("FAIL rs_wait_wr: got ok=%b rstn=%b busy=%b idx=%0d expected 1 0 1 0",
        ok, rstn_out, busy, tbl_idx);
    end
    clear_log();
    wait_idle(ok);
    n_tests++;
    if (!ok || ex_cyc.size() != 3 || ex_addr[0] !== 16'h0100
        || init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_rerun: got n=%0d addr0=%h done=%b expected 3 0100 1",
        ex_cyc.size(), ex_addr[0], init_done);
    end
  endtask

  task automatic test_boundary();
    bit ok;
    for (int i = 0; i < RN; i++)
      rom[i] = ent(2'b00, AW'(16'h0300 + i), DW'(i));
    start_run();
    wait_idle(ok);
    n_tests++;
    if (!ok || ex_cyc.size() != RN) begin
      n_fail++;
      $display("FAIL bnd_count: got ok=%0d n=%0d expected 8",
        ok, ex_cyc.size());
    end
    n_tests++;
    if ({init_done, tbl_idx, ex_addr[7]} !== {1'b1, 3'd7, 16'h0307}) begin
      n_fail++;
      $display("FAIL bnd_end: got done=%b idx=%0d addr=%h expected 1 7 0307",
        init_done, tbl_idx, ex_addr[7]);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    load_writes();
    start_run();
    wait_exec(ok);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ok, rstn_out, i2c_exec, busy, tbl_idx} !== {4'b1001, 3'd0}) begin
      n_fail++;
      $display("FAIL mid_rst: got ok=%b rstn=%b exec=%b busy=%b idx=%0d expected 1 0 0 1 0",
        ok, rstn_out, i2c_exec, busy, tbl_idx);
    end
    rst_n = 1'b1;
    clear_log();
    wait_idle(ok);
    n_tests++;
    if (!ok || ex_cyc.size() != 3 || ex_addr[0] !== 16'h0100
        || init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rerun: got n=%0d addr0=%h done=%b expected 3 0100 1",
        ex_cyc.size(), ex_addr[0], init_done);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_write_seq();
    test_verify_ok();
    test_verify_fail();
    test_restart();
    test_delay();
    test_boundary();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
